// File: rtl/aes_cipher_control.sv
// Round sequencer for the AES cipher datapath: one request per handshake, one round per cycle,
// completion returned on out_valid/out_ready. Selects and write enables are decoded each cycle.
module aes_cipher_control (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    input  logic       op_i,
    input  logic [2:0] key_len_i,
    input  logic       start_i,
    input  logic       dec_key_gen_i,
    input  logic       key_clear_i,
    input  logic       data_out_clear_i,
    output logic       dec_key_gen_o,
    output logic       key_clear_o,
    output logic       data_out_clear_o,
    output logic [1:0] state_sel_o,
    output logic       state_we_o,
    output logic [1:0] add_rk_sel_o,
    output logic [1:0] key_full_sel_o,
    output logic       key_full_we_o,
    output logic       key_dec_we_o,
    output logic [3:0] round_o
);

    localparam int unsigned RoundW = 4;

    localparam logic [1:0] StateSelInit  = 2'd0;
    localparam logic [1:0] StateSelRound = 2'd1;
    localparam logic [1:0] StateSelClear = 2'd2;

    localparam logic [1:0] AddRkSelInit  = 2'd0;
    localparam logic [1:0] AddRkSelRound = 2'd1;
    localparam logic [1:0] AddRkSelFinal = 2'd2;

    localparam logic [1:0] KeyFullSelEncInit = 2'd0;
    localparam logic [1:0] KeyFullSelDecInit = 2'd1;
    localparam logic [1:0] KeyFullSelRound   = 2'd2;
    localparam logic [1:0] KeyFullSelClear   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        FINISH = 2'd2,
        CLEAR  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [RoundW-1:0]   round_q, round_d;
    logic [RoundW-1:0]   num_rounds_q, num_rounds_d;
    logic                dec_key_gen_q, dec_key_gen_d;
    logic                key_clear_q, key_clear_d;
    logic                data_out_clear_q, data_out_clear_d;
    logic [RoundW-1:0]   num_rounds_req;

    // Non-one-hot key length codes fall back to AES-128.
    always_comb begin
        num_rounds_req = RoundW'(10);
        case (key_len_i)
            3'b010:  num_rounds_req = RoundW'(12);
            3'b100:  num_rounds_req = RoundW'(14);
            default: num_rounds_req = RoundW'(10);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            round_q          <= '0;
            num_rounds_q     <= RoundW'(10);
            dec_key_gen_q    <= 1'b0;
            key_clear_q      <= 1'b0;
            data_out_clear_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            round_q          <= round_d;
            num_rounds_q     <= num_rounds_d;
            dec_key_gen_q    <= dec_key_gen_d;
            key_clear_q      <= key_clear_d;
            data_out_clear_q <= data_out_clear_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        round_d          = round_q;
        num_rounds_d     = num_rounds_q;
        dec_key_gen_d    = dec_key_gen_q;
        key_clear_d      = key_clear_q;
        data_out_clear_d = data_out_clear_q;

        in_ready_o     = 1'b0;
        out_valid_o    = 1'b0;
        state_sel_o    = StateSelInit;
        state_we_o     = 1'b0;
        add_rk_sel_o   = AddRkSelInit;
        key_full_sel_o = KeyFullSelEncInit;
        key_full_we_o  = 1'b0;
        key_dec_we_o   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (start_i) begin
                        num_rounds_d     = num_rounds_req;
                        dec_key_gen_d    = dec_key_gen_i;
                        key_clear_d      = 1'b0;
                        data_out_clear_d = 1'b0;
                        state_sel_o      = StateSelInit;
                        state_we_o       = ~dec_key_gen_i;
                        add_rk_sel_o     = AddRkSelInit;
                        key_full_we_o    = 1'b1;
                        key_full_sel_o   = (op_i && !dec_key_gen_i) ? KeyFullSelDecInit
                                                                    : KeyFullSelEncInit;
                        round_d          = '0;
                        state_d          = ROUND;
                    end else if (key_clear_i || data_out_clear_i) begin
                        key_clear_d      = key_clear_i;
                        data_out_clear_d = data_out_clear_i;
                        state_d          = CLEAR;
                    end
                end
            end

            ROUND: begin
                state_sel_o    = StateSelRound;
                state_we_o     = ~dec_key_gen_q;
                key_full_sel_o = KeyFullSelRound;
                key_full_we_o  = 1'b1;
                // Counter holds on the last round so it stays within 0..13.
                if (round_q == num_rounds_q - RoundW'(1)) begin
                    add_rk_sel_o = AddRkSelFinal;
                    key_dec_we_o = dec_key_gen_q;
                    state_d      = FINISH;
                end else begin
                    add_rk_sel_o = AddRkSelRound;
                    round_d      = round_q + RoundW'(1);
                end
            end

            CLEAR: begin
                if (key_clear_q) begin
                    key_full_sel_o = KeyFullSelClear;
                    key_full_we_o  = 1'b1;
                    key_dec_we_o   = 1'b1;
                end
                if (data_out_clear_q) begin
                    state_sel_o = StateSelClear;
                    state_we_o  = 1'b1;
                end
                state_d = FINISH;
            end

            FINISH: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    round_d          = '0;
                    dec_key_gen_d    = 1'b0;
                    key_clear_d      = 1'b0;
                    data_out_clear_d = 1'b0;
                    state_d          = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign dec_key_gen_o    = dec_key_gen_q;
    assign key_clear_o      = key_clear_q;
    assign data_out_clear_o = data_out_clear_q;
    assign round_o          = round_q;

endmodule

// File: tb/tb_aes_cipher_control.sv
// Directed bench for aes_cipher_control: per-cycle expected outputs derived from operation
// parameters, checked on every falling edge, plus literal latency/round pins.
module tb_aes_cipher_control;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       op_i;
    logic [2:0] key_len_i;
    logic       start_i;
    logic       dec_key_gen_i;
    logic       key_clear_i;
    logic       data_out_clear_i;
    logic       dec_key_gen_o;
    logic       key_clear_o;
    logic       data_out_clear_o;
    logic [1:0] state_sel_o;
    logic       state_we_o;
    logic [1:0] add_rk_sel_o;
    logic [1:0] key_full_sel_o;
    logic       key_full_we_o;
    logic       key_dec_we_o;
    logic [3:0] round_o;

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       dkg;
        logic       kc;
        logic       doc;
        logic [1:0] ss;
        logic       swe;
        logic [1:0] ark;
        logic [1:0] kfs;
        logic       kfwe;
        logic       kdwe;
        logic [3:0] rnd;
    } obs_t;

    obs_t  act, exp_o;
    string name = "reset";
    bit    chk_en = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    ov_lat = -1;
    bit    ov_seen = 1'b1;
    int    fin_rnd = -1;
    int    kdwe_rnd = -1;

    aes_cipher_control dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .op_i             (op_i),
        .key_len_i        (key_len_i),
        .start_i          (start_i),
        .dec_key_gen_i    (dec_key_gen_i),
        .key_clear_i      (key_clear_i),
        .data_out_clear_i (data_out_clear_i),
        .dec_key_gen_o    (dec_key_gen_o),
        .key_clear_o      (key_clear_o),
        .data_out_clear_o (data_out_clear_o),
        .state_sel_o      (state_sel_o),
        .state_we_o       (state_we_o),
        .add_rk_sel_o     (add_rk_sel_o),
        .key_full_sel_o   (key_full_sel_o),
        .key_full_we_o    (key_full_we_o),
        .key_dec_we_o     (key_dec_we_o),
        .round_o          (round_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign act = {in_ready_o, out_valid_o, dec_key_gen_o, key_clear_o, data_out_clear_o,
                  state_sel_o, state_we_o, add_rk_sel_o, key_full_sel_o, key_full_we_o,
                  key_dec_we_o, round_o};

    // Single per-cycle compare against the expected vector; also records observations for literal pins.
    always @(negedge clk_i) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp_o);
            end
            if (out_valid_o && !ov_seen) begin
                ov_lat  = cyc - acc_cyc;
                ov_seen = 1'b1;
            end
            if (add_rk_sel_o == 2'd2) fin_rnd = int'(round_o);
            if (key_dec_we_o) kdwe_rnd = int'(round_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    function automatic int nr_of(input logic [2:0] kl);
        if (kl == 3'b010) return 12;
        if (kl == 3'b100) return 14;
        return 10;
    endfunction

    task automatic lit(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_o          = '0;
        exp_o.in_ready = 1'b1;
    endtask

    task automatic finish_phase(input logic dkg, input logic kc, input logic doc,
                                input logic [3:0] rnd, input int stall);
        exp_o           = '0;
        exp_o.out_valid = 1'b1;
        exp_o.dkg       = dkg;
        exp_o.kc        = kc;
        exp_o.doc       = doc;
        exp_o.rnd       = rnd;
        out_ready_i     = 1'b0;
        repeat (stall) step();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        set_idle_exp();
    endtask

    task automatic run_cipher(input string nm, input logic op, input logic [2:0] kl,
                              input logic dkg, input logic kc, input logic doc,
                              input int stall, input int abort_at);
        int nr;
        nr               = nr_of(kl);
        name             = nm;
        in_valid_i       = 1'b1;
        start_i          = 1'b1;
        op_i             = op;
        key_len_i        = kl;
        dec_key_gen_i    = dkg;
        key_clear_i      = kc;
        data_out_clear_i = doc;
        out_ready_i      = 1'b1;
        set_idle_exp();
        exp_o.swe  = !dkg;
        exp_o.kfs  = (op && !dkg) ? 2'd1 : 2'd0;
        exp_o.kfwe = 1'b1;
        acc_cyc    = cyc;
        ov_seen    = 1'b0;
        step();
        in_valid_i       = 1'b0;
        start_i          = 1'b0;
        key_clear_i      = 1'b0;
        data_out_clear_i = 1'b0;
        for (int k = 0; k < nr; k++) begin
            if (k == abort_at) begin
                rst_ni = 1'b0;
                set_idle_exp();
                step();
                rst_ni = 1'b1;
                return;
            end
            exp_o      = '0;
            exp_o.dkg  = dkg;
            exp_o.ss   = 2'd1;
            exp_o.swe  = !dkg;
            exp_o.kfs  = 2'd2;
            exp_o.kfwe = 1'b1;
            exp_o.ark  = (k == nr - 1) ? 2'd2 : 2'd1;
            exp_o.kdwe = (k == nr - 1) && dkg;
            exp_o.rnd  = 4'(k);
            step();
        end
        finish_phase(dkg, 1'b0, 1'b0, 4'(nr - 1), stall);
    endtask

    task automatic run_clear(input string nm, input logic kc, input logic doc, input int stall);
        name             = nm;
        in_valid_i       = 1'b1;
        start_i          = 1'b0;
        key_clear_i      = kc;
        data_out_clear_i = doc;
        set_idle_exp();
        acc_cyc = cyc;
        ov_seen = 1'b0;
        step();
        in_valid_i       = 1'b0;
        key_clear_i      = 1'b0;
        data_out_clear_i = 1'b0;
        exp_o     = '0;
        exp_o.kc  = kc;
        exp_o.doc = doc;
        if (kc) begin
            exp_o.kfs  = 2'd3;
            exp_o.kfwe = 1'b1;
            exp_o.kdwe = 1'b1;
        end
        if (doc) begin
            exp_o.ss  = 2'd2;
            exp_o.swe = 1'b1;
        end
        step();
        finish_phase(1'b0, kc, doc, 4'd0, stall);
    endtask

    initial begin
        rst_ni           = 1'b0;
        in_valid_i       = 1'b0;
        out_ready_i      = 1'b0;
        op_i             = 1'b0;
        key_len_i        = 3'b001;
        start_i          = 1'b0;
        dec_key_gen_i    = 1'b0;
        key_clear_i      = 1'b0;
        data_out_clear_i = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        repeat (2) step();
        rst_ni = 1'b1;
        name   = "idle";
        repeat (2) step();

        name       = "idle_noop_accept";
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();

        run_cipher("aes128_enc", 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 0, -1);
        lit("lat128", ov_lat, 11);
        lit("final_rnd128", fin_rnd, 9);

        run_cipher("aes256_dec", 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 2, -1);
        lit("lat256", ov_lat, 15);
        lit("final_rnd256", fin_rnd, 13);

        run_cipher("aes192_dkg", 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1, -1);
        lit("lat192", ov_lat, 13);
        lit("kdwe_rnd192", kdwe_rnd, 11);

        run_clear("clear_both", 1'b1, 1'b1, 5);
        lit("lat_clear", ov_lat, 2);
        run_clear("clear_data", 1'b0, 1'b1, 0);
        run_clear("clear_key", 1'b1, 1'b0, 1);

        run_cipher("nonhot_keylen", 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 0, -1);
        lit("lat_nonhot", ov_lat, 11);

        run_cipher("abort_round5", 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 0, 5);
        name = "after_abort";
        step();
        lit("abort_no_valid", int'(out_valid_o), 0);

        run_cipher("start_over_clear", 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 0, -1);
        lit("lat_start_clear", ov_lat, 11);
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
